bcd_counter_n: RTL
==================

Name: bcd_counter_n

Overview:
Parametrised multi-digit BCD up/down counter with a programmable terminal value, synchronous load, and wrap or saturate mode. It is the general replacement for the fixed two-digit BCD counters used in the clock, timer and stopwatch display paths. Digit count is a parameter, so one module covers seconds and minutes (2 digits), milliseconds (3 digits) and day counters. Output feeds seven-segment decoders directly; `carry` chains to the next counter stage.

Parameters:
DIGITS, 2, number of BCD digits (1..8); count width is 4*DIGITS.
BOUND, 8'h59, upper terminal value, packed BCD, 4*DIGITS bits; every nibble must be 0..9.
SATURATE, 0, 0 = wrap at terminal; 1 = hold at terminal.

Ports:
clk  in  1  clock; all state updates on its rising edge.
reset  in  1  synchronous, active-low reset (0 = reset).
ena  in  1  count enable; one step per cycle while high.
set  in  1  synchronous load of set_num.
set_num  in  4*DIGITS  load value, packed BCD.
updown  in  1  count direction: 0 = up, 1 = down.
cnt  out  4*DIGITS  current count, packed BCD, registered.
carry  out  1  terminal pulse, combinational.
is_zero  out  1  high when cnt == 0, combinational.

Behaviour:
- Priority on each rising clk edge: reset low > set > ena > hold.
- Reset: cnt = 0. Reset applies even when set or ena is high. After reset, carry and is_zero follow cnt = 0 combinationally.
- Terminal value: BOUND when updown = 0; 0 when updown = 1.
- carry = ena & ~set & (cnt == terminal). It is combinational and uses the current updown. It is a single-cycle pulse per terminal event in wrap mode.
- Up step: digit 0 increments. Digit i increments only when every lower digit is 9. Any digit that is 9 and being stepped goes to 0.
- Down step: digit 0 decrements. Digit i decrements only when every lower digit is 0. Any digit that is 0 and being stepped goes to 9.
- Wrap (SATURATE = 0):
  - Up with cnt == BOUND and ena high: cnt = 0 next cycle.
  - Down with cnt == 0 and ena high: cnt = BOUND next cycle.
  - The wrap is a whole-word load, not a per-digit step. Intermediate digits above BOUND digits (e.g. 60..99 for BOUND 59) are never reached.
- Saturate (SATURATE = 1): at terminal with ena high, cnt holds, and carry stays high every enabled cycle.
- Load sanitising, in this order:
  1. Any set_num nibble > 9 is replaced by 9.
  2. If the resulting value > BOUND, BOUND is loaded.
  - The loaded value appears on cnt the cycle after set.
- Out-of-range cnt cannot arise from legal operation. If BOUND itself is invalid BCD, behaviour is undefined; a simulation-time check flags it.
- Direction change: updown may toggle on any cycle. The step taken on an edge uses the updown value sampled at that edge, and carry uses the current updown. No pipeline; latency from ena to cnt change is 1 cycle.
- ena low: cnt holds and carry is 0, regardless of cnt.
- Width rule: all comparisons are full 4*DIGITS-bit unsigned. There is no binary arithmetic across nibbles; each digit steps mod 10.
- Cascading: stage N+1 ena = stage N carry, with both stages sharing the same clk, reset and updown. The chain must count correctly with no extra cycle of delay.

Test Plan:
1. Up-count wrap (DIGITS=2, BOUND=8'h59, SATURATE=0): reset, then ena=1, updown=0 for 60 cycles. cnt steps 00..59 in BCD (09→10, 49→50). carry is high only during the cycle cnt=59. Next cnt = 00.
2. Down-count wrap (same configuration): start cnt=00, updown=1, ena=1. carry is high at cnt=00, next cnt=59, then 58; 50→49 and 10→09 borrow correctly.
3. Load sanitising (same configuration):
   - set=1, set_num=8'h7A → cnt=59 (clamped 79, then limited to BOUND).
   - set_num=8'h3F → cnt=39.
   - set=1 together with ena=1 → load wins and no step occurs; carry=0 in that cycle.
4. Saturate (DIGITS=2, BOUND=8'h23, SATURATE=1):
   - Count up to 23 and hold 10 more enabled cycles: cnt stays 23 and carry stays 1 throughout.
   - Switch updown=1: cnt=22 next cycle and carry drops.
5. Reset priority: reset=0 with set=1, set_num=8'h12, ena=1 mid-count at cnt=37. Next edge cnt=00 and is_zero=1. Release reset: counting resumes from 00.
6. Cascade and multi-digit (DIGITS=3, BOUND=12'h999, chained to a DIGITS=1, BOUND=4'h5 stage via carry):
   - Count up from 998: 998, 999, then 000 with the upper stage incrementing by exactly 1.
   - Toggle updown at 100: next value is 099 with no upper-stage change.

Source files
------------

// File: rtl/bcd_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter_n
// Purpose  : Multi-digit packed-BCD up/down counter with programmable terminal
//            value, sanitised synchronous load, and wrap or saturate mode.
//            The combinational carry lets stages be chained without extra delay.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_counter_n #(
  parameter int                  DIGITS   = 2,
  parameter logic [4*DIGITS-1:0] BOUND    = (4*DIGITS)'(32'h59),
  parameter int                  SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic                  set,
  input  logic [4*DIGITS-1:0]   set_num,
  input  logic                  updown,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  carry,
  output logic                  is_zero
);

  localparam int W = 4*DIGITS;

  logic [W-1:0]      r_cnt;
  logic [W-1:0]      w_terminal;
  logic [W-1:0]      w_wrap;
  logic [W-1:0]      w_step;
  logic [W-1:0]      w_clamped;
  logic [W-1:0]      w_load;
  logic              w_at_term;
  logic [DIGITS-1:0] w_lower9;
  logic [DIGITS-1:0] w_lower0;
  logic [DIGITS-1:0] w_bound_ok;

  // Terminal depends on the direction currently presented; the wrap target is
  // the opposite end of the range, loaded as a whole word.
  assign w_terminal = updown ? '0 : BOUND;
  assign w_wrap     = updown ? BOUND : '0;
  assign w_at_term  = (r_cnt == w_terminal);

  assign cnt     = r_cnt;
  assign carry   = ena & ~set & w_at_term;
  assign is_zero = (r_cnt == '0);

  // Per-digit stepping: a digit moves only when every lower digit is at its
  // rollover value (9 going up, 0 going down); each digit steps mod 10.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] w_d;
    logic [3:0] w_up_d;
    logic [3:0] w_dn_d;

    assign w_d    = r_cnt[4*i +: 4];
    assign w_up_d = (w_d == 4'd9) ? 4'd0 : w_d + 4'd1;
    assign w_dn_d = (w_d == 4'd0) ? 4'd9 : w_d - 4'd1;

    if (i == 0) begin : g_first
      assign w_lower9[i] = 1'b1;
      assign w_lower0[i] = 1'b1;
    end else begin : g_chain
      assign w_lower9[i] = w_lower9[i-1] & (r_cnt[4*(i-1) +: 4] == 4'd9);
      assign w_lower0[i] = w_lower0[i-1] & (r_cnt[4*(i-1) +: 4] == 4'd0);
    end

    assign w_step[4*i +: 4] = updown ? (w_lower0[i] ? w_dn_d : w_d)
                                     : (w_lower9[i] ? w_up_d : w_d);

    // Non-decimal load nibbles are forced to 9 before the range limit.
    assign w_clamped[4*i +: 4] = (set_num[4*i +: 4] > 4'd9) ? 4'd9 : set_num[4*i +: 4];

    assign w_bound_ok[i] = (BOUND[4*i +: 4] <= 4'd9);
  end

  // Valid BCD orders the same as binary, so a full-width compare limits the load.
  assign w_load = (w_clamped > BOUND) ? BOUND : w_clamped;

  // Count register: reset beats load, load beats counting, otherwise hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (set) begin
      r_cnt <= w_load;
    end else if (ena) begin
      if (w_at_term) begin
        r_cnt <= (SATURATE != 0) ? r_cnt : w_wrap;
      end else begin
        r_cnt <= w_step;
      end
    end
  end

  // Flags a BOUND that is not valid packed BCD; behaviour is undefined then.
  always_ff @(posedge clk) begin
    bound_is_bcd: assert (&w_bound_ok);
  end

endmodule
`default_nettype wire
